tcp_rx_ctrl: RTL and testbench

TCP_RX_CTRL -- requirements
Module: tcp_rx_ctrl

---
 rtl/tcp_misc_pkg.sv | 21 ++
 rtl/tcp_pkg.sv | 10 +
 rtl/tcp_rx_ctrl_join.sv | 37 +++
 rtl/tcp_rx_ctrl.sv | 136 +++++++++++++
 tb/tb_tcp_rx_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcp_misc_pkg.sv
// Receive-controller state encoding and join sizes.
package tcp_misc_pkg;

  localparam int unsigned RxWrJoinN  = 3;
  localparam int unsigned RxNewJoinN = 2;
  localparam int unsigned RxDoneW    = RxWrJoinN;

  typedef enum logic [3:0] {
    StIdle,
    StLookup,
    StLookupWait,
    StRdReq,
    StRdWait,
    StCalc,
    StWr,
    StNewAlloc,
    StNewWr,
    StSynack
  } rx_ctrl_state_e;

endpackage

// File: rtl/tcp_pkg.sv
// Shared TCP engine widths used by the flow tables and buffer pointers.
package tcp_pkg;

  localparam int unsigned FlowIdW = 3;
  localparam int unsigned PtrW    = 16;

  typedef logic [FlowIdW-1:0] flowid_t;
  typedef logic [PtrW-1:0]    tcp_ptr_t;

endpackage

// File: rtl/tcp_rx_ctrl_join.sv
// N-way valid/rdy fan-out: each valid drops after its own handshake; all_done marks the last one.
module tcp_rx_ctrl_join #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         active,
  input  logic [N-1:0] rdy,
  output logic [N-1:0] val,
  output logic         all_done
);

  logic [N-1:0] done_q;
  logic [N-1:0] done_d;
  logic [N-1:0] fire;

  always_comb begin
    val      = active ? ~done_q : '0;
    fire     = val & rdy;
    all_done = active && (&(done_q | fire));
    // Bits clear when the group completes or the owning state is left.
    if (!active || all_done) begin
      done_d = '0;
    end else begin
      done_d = done_q | fire;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/tcp_rx_ctrl.sv
// Receive-path control FSM: flow lookup, state read/update, and new-flow setup with SYN-ACK.
module tcp_rx_ctrl
  import tcp_misc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_hdr_val,
  output logic        rx_hdr_rdy,
  input  logic        rx_hdr_syn,
  output logic        ctrl_datap_save_input,
  output logic        ctrl_datap_save_flow_state,
  output logic        ctrl_datap_save_calcs,
  output logic        store_flowid_cam,
  output logic        store_flowid_manager,
  output logic        read_flow_cam_val,
  input  logic        read_flow_cam_rdy,
  input  logic        read_flow_cam_resp_val,
  input  logic        read_flow_cam_hit,
  output logic        flow_rd_req_val,
  input  logic        flow_rd_req_rdy,
  input  logic        flow_rd_resp_val,
  output logic        flow_wr_req_val,
  input  logic        flow_wr_req_rdy,
  output logic        rx_sched_update_val,
  input  logic        rx_sched_update_rdy,
  output logic        tcp_rx_dst_hdr_val,
  input  logic        tcp_rx_dst_hdr_rdy,
  output logic        flowid_manager_req_val,
  input  logic        flowid_manager_req_rdy,
  output logic        new_flow_val,
  input  logic        new_flow_rdy,
  output logic        app_new_flow_notif_val,
  input  logic        app_new_flow_notif_rdy,
  output logic        slow_path_send_pkt_enqueue_val,
  input  logic        slow_path_send_pkt_enqueue_rdy,
  output logic [31:0] rx_drop_cnt
);

  rx_ctrl_state_e state_q;
  logic           syn_q;
  logic [31:0]    drop_cnt_q;

  logic                 run;
  logic                 wr_active;
  logic                 new_active;
  logic [RxDoneW-1:0]   wr_val;
  logic [RxDoneW-1:0]   wr_rdy;
  logic                 wr_done;
  logic [RxNewJoinN-1:0] new_val;
  logic [RxNewJoinN-1:0] new_rdy;
  logic                 new_done;

  // Every strobe is gated by reset so nothing escapes while the segment is being abandoned.
  assign run        = ~rst;
  assign wr_active  = run && (state_q == StWr);
  assign new_active = run && (state_q == StNewWr);

  assign rx_hdr_rdy             = run && (state_q == StIdle);
  assign ctrl_datap_save_input  = rx_hdr_rdy && rx_hdr_val;
  assign read_flow_cam_val      = run && (state_q == StLookup);
  assign store_flowid_cam       = run && (state_q == StLookupWait) && read_flow_cam_resp_val
                                  && read_flow_cam_hit;
  assign flow_rd_req_val        = run && (state_q == StRdReq);
  assign ctrl_datap_save_flow_state = run && (state_q == StRdWait) && flow_rd_resp_val;
  assign ctrl_datap_save_calcs  = run && (state_q == StCalc);
  assign flowid_manager_req_val = run && (state_q == StNewAlloc);
  assign store_flowid_manager   = flowid_manager_req_val && flowid_manager_req_rdy;
  assign slow_path_send_pkt_enqueue_val = run && (state_q == StSynack);
  assign rx_drop_cnt            = drop_cnt_q;

  assign wr_rdy = {tcp_rx_dst_hdr_rdy, rx_sched_update_rdy, flow_wr_req_rdy};
  assign {tcp_rx_dst_hdr_val, rx_sched_update_val, flow_wr_req_val} = wr_val;
  assign new_rdy = {app_new_flow_notif_rdy, new_flow_rdy};
  assign {app_new_flow_notif_val, new_flow_val} = new_val;

  tcp_rx_ctrl_join #(
    .N(RxDoneW)
  ) u_wr_join (
    .clk     (clk),
    .rst     (rst),
    .active  (wr_active),
    .rdy     (wr_rdy),
    .val     (wr_val),
    .all_done(wr_done)
  );

  tcp_rx_ctrl_join #(
    .N(RxNewJoinN)
  ) u_new_join (
    .clk     (clk),
    .rst     (rst),
    .active  (new_active),
    .rdy     (new_rdy),
    .val     (new_val),
    .all_done(new_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      syn_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_hdr_val) begin
            syn_q   <= rx_hdr_syn;
            state_q <= StLookup;
          end
        end
        StLookup:     if (read_flow_cam_rdy) state_q <= StLookupWait;
        StLookupWait: begin
          if (read_flow_cam_resp_val) begin
            if (read_flow_cam_hit) begin
              state_q <= StRdReq;
            end else if (syn_q) begin
              state_q <= StNewAlloc;
            end else begin
              drop_cnt_q <= drop_cnt_q + 32'd1;
              state_q    <= StIdle;
            end
          end
        end
        StRdReq:    if (flow_rd_req_rdy) state_q <= StRdWait;
        StRdWait:   if (flow_rd_resp_val) state_q <= StCalc;
        StCalc:     state_q <= StWr;
        StWr:       if (wr_done) state_q <= StIdle;
        StNewAlloc: if (flowid_manager_req_rdy) state_q <= StNewWr;
        StNewWr:    if (new_done) state_q <= StSynack;
        StSynack:   if (slow_path_send_pkt_enqueue_rdy) state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_rx_ctrl.sv
// Self-checking bench for tcp_rx_ctrl: directed scenarios plus randomized segments vs a count/latency model.
module tb_tcp_rx_ctrl;

  logic        clk;
  logic        rst;
  logic        rx_hdr_val, rx_hdr_rdy, rx_hdr_syn;
  logic        ctrl_datap_save_input, ctrl_datap_save_flow_state, ctrl_datap_save_calcs;
  logic        store_flowid_cam, store_flowid_manager;
  logic        read_flow_cam_val, read_flow_cam_rdy, read_flow_cam_resp_val, read_flow_cam_hit;
  logic        flow_rd_req_val, flow_rd_req_rdy, flow_rd_resp_val;
  logic        flow_wr_req_val, flow_wr_req_rdy;
  logic        rx_sched_update_val, rx_sched_update_rdy;
  logic        tcp_rx_dst_hdr_val, tcp_rx_dst_hdr_rdy;
  logic        flowid_manager_req_val, flowid_manager_req_rdy;
  logic        new_flow_val, new_flow_rdy;
  logic        app_new_flow_notif_val, app_new_flow_notif_rdy;
  logic        slow_path_send_pkt_enqueue_val, slow_path_send_pkt_enqueue_rdy;
  logic [31:0] rx_drop_cnt;

  tcp_rx_ctrl dut (
    .clk                           (clk),
    .rst                           (rst),
    .rx_hdr_val                    (rx_hdr_val),
    .rx_hdr_rdy                    (rx_hdr_rdy),
    .rx_hdr_syn                    (rx_hdr_syn),
    .ctrl_datap_save_input         (ctrl_datap_save_input),
    .ctrl_datap_save_flow_state    (ctrl_datap_save_flow_state),
    .ctrl_datap_save_calcs         (ctrl_datap_save_calcs),
    .store_flowid_cam              (store_flowid_cam),
    .store_flowid_manager          (store_flowid_manager),
    .read_flow_cam_val             (read_flow_cam_val),
    .read_flow_cam_rdy             (read_flow_cam_rdy),
    .read_flow_cam_resp_val        (read_flow_cam_resp_val),
    .read_flow_cam_hit             (read_flow_cam_hit),
    .flow_rd_req_val               (flow_rd_req_val),
    .flow_rd_req_rdy               (flow_rd_req_rdy),
    .flow_rd_resp_val              (flow_rd_resp_val),
    .flow_wr_req_val               (flow_wr_req_val),
    .flow_wr_req_rdy               (flow_wr_req_rdy),
    .rx_sched_update_val           (rx_sched_update_val),
    .rx_sched_update_rdy           (rx_sched_update_rdy),
    .tcp_rx_dst_hdr_val            (tcp_rx_dst_hdr_val),
    .tcp_rx_dst_hdr_rdy            (tcp_rx_dst_hdr_rdy),
    .flowid_manager_req_val        (flowid_manager_req_val),
    .flowid_manager_req_rdy        (flowid_manager_req_rdy),
    .new_flow_val                  (new_flow_val),
    .new_flow_rdy                  (new_flow_rdy),
    .app_new_flow_notif_val        (app_new_flow_notif_val),
    .app_new_flow_notif_rdy        (app_new_flow_notif_rdy),
    .slow_path_send_pkt_enqueue_val(slow_path_send_pkt_enqueue_val),
    .slow_path_send_pkt_enqueue_rdy(slow_path_send_pkt_enqueue_rdy),
    .rx_drop_cnt                   (rx_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Interface index: 0 cam, 1 rd, 2 wr, 3 sched, 4 dst, 5 mgr, 6 new, 7 notif, 8 synack
  localparam int NIf = 9;

  int tests = 0;
  int fails = 0;

  int hold   [NIf];
  int waited [NIf];
  int vcyc   [NIf];
  int hs     [NIf];
  int lat_cam, lat_rd, cam_cd, rd_cd;
  bit cam_hit, hdr_pending, accepted, rst_req, prev_rst;
  logic [NIf-1:0] prev_v, prev_r;
  int n_sin, n_sfs, n_calcs, n_scam, n_smgr, stab_err;
  logic rst_rdy_obs;
  logic [NIf-1:0] rst_v_obs;
  longint exp_drop;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NIf-1:0] get_val();
    return {slow_path_send_pkt_enqueue_val, app_new_flow_notif_val, new_flow_val,
            flowid_manager_req_val, tcp_rx_dst_hdr_val, rx_sched_update_val,
            flow_wr_req_val, flow_rd_req_val, read_flow_cam_val};
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < NIf; i++) begin
      vcyc[i] = 0;
      hs[i]   = 0;
    end
    n_sin = 0; n_sfs = 0; n_calcs = 0; n_scam = 0; n_smgr = 0; stab_err = 0;
  endtask

  // One clock: drive inputs 1 time unit after the edge, sample 1 unit later.
  task automatic tick();
    logic [NIf-1:0] v, r;
    @(posedge clk);
    #1;
    rst = rst_req;
    if (rst_req) begin
      cam_cd = 0;
      rd_cd  = 0;
      for (int i = 0; i < NIf; i++) waited[i] = 0;
    end
    rst_req = 1'b0;
    read_flow_cam_resp_val = (cam_cd == 1);
    read_flow_cam_hit      = (cam_cd == 1) ? cam_hit : 1'($urandom);
    if (cam_cd > 0) cam_cd--;
    flow_rd_resp_val = (rd_cd == 1);
    if (rd_cd > 0) rd_cd--;
    rx_hdr_val = hdr_pending;
    if (!hdr_pending) rx_hdr_syn = 1'($urandom);
    for (int i = 0; i < NIf; i++) r[i] = (waited[i] >= hold[i]);
    {slow_path_send_pkt_enqueue_rdy, app_new_flow_notif_rdy, new_flow_rdy,
     flowid_manager_req_rdy, tcp_rx_dst_hdr_rdy, rx_sched_update_rdy,
     flow_wr_req_rdy, flow_rd_req_rdy, read_flow_cam_rdy} = r;
    #1;
    v = get_val();
    for (int i = 0; i < NIf; i++) begin
      if (v[i]) vcyc[i]++;
      if (v[i] && r[i]) begin
        hs[i]++;
        waited[i] = 0;
      end else if (v[i]) begin
        waited[i]++;
      end
      if (!rst && !prev_rst && prev_v[i] && !prev_r[i] && !v[i]) stab_err++;
    end
    if (v[0] && r[0]) cam_cd = lat_cam;
    if (v[1] && r[1]) rd_cd = lat_rd;
    if (ctrl_datap_save_input) n_sin++;
    if (ctrl_datap_save_flow_state) n_sfs++;
    if (ctrl_datap_save_calcs) n_calcs++;
    if (store_flowid_cam) n_scam++;
    if (store_flowid_manager) n_smgr++;
    if (rst) begin
      rst_rdy_obs = rx_hdr_rdy;
      rst_v_obs   = v;
    end
    if (rx_hdr_val && rx_hdr_rdy) begin
      hdr_pending = 1'b0;
      accepted    = 1'b1;
    end
    prev_v = v; prev_r = r; prev_rst = rst;
  endtask

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Cycles from header acceptance back to an accepting controller, from the state-walk rules.
  function automatic int model_lat(input bit syn, input bit hit);
    int base;
    base = 1 + (1 + hold[0]) + lat_cam;
    if (hit) return base + (1 + hold[1]) + lat_rd + 1 + (1 + max3(hold[2], hold[3], hold[4]));
    if (syn) return base + (1 + hold[5]) + (1 + max3(hold[6], hold[7], 0)) + (1 + hold[8]);
    return base;
  endfunction

  task automatic run_segment(input string name, input bit syn, input bit hit, input bit abort);
    int  lat, rst_at;
    bit  done, rst_done;
    bit  exp_hs [NIf];
    clear_counts();
    cam_hit     = hit;
    rx_hdr_syn  = syn;
    hdr_pending = 1'b1;
    accepted    = 1'b0;
    for (int k = 0; k < 50 && !accepted; k++) tick();
    if (!accepted) begin
      check({name, " accept timeout"}, 0, 1);
      hdr_pending = 1'b0;
      return;
    end
    lat = 0; done = 1'b0; rst_done = 1'b0; rst_at = -1;
    for (int k = 0; k < 400 && !done; k++) begin
      tick();
      lat++;
      if (rst) rst_at = lat;
      if (rx_hdr_rdy) done = 1'b1;
      if (abort && !rst_done && hs[1] == 1) begin
        rst_req  = 1'b1;
        rst_done = 1'b1;
      end
    end
    if (!done) check({name, " idle timeout"}, 0, 1);

    if (abort) begin
      exp_drop = 0;
      for (int i = 0; i < NIf; i++) exp_hs[i] = (i <= 1);
      check({name, " rdy during rst"}, longint'(rst_rdy_obs), 0);
      check({name, " vals during rst"}, longint'(rst_v_obs), 0);
      check({name, " idle after rst"}, lat, rst_at + 1);
      check({name, " save_flow_state"}, n_sfs, 0);
      check({name, " store_cam"}, n_scam, 1);
    end else begin
      if (!hit && !syn) exp_drop++;
      exp_hs[0] = 1'b1;
      for (int i = 1; i <= 4; i++) exp_hs[i] = hit;
      for (int i = 5; i <= 8; i++) exp_hs[i] = !hit && syn;
      check({name, " latency"}, lat, model_lat(syn, hit));
      check({name, " save_flow_state"}, n_sfs, hit);
      check({name, " save_calcs"}, n_calcs, hit);
      check({name, " store_cam"}, n_scam, hit);
      check({name, " store_mgr"}, n_smgr, !hit && syn);
    end
    check({name, " save_input"}, n_sin, 1);
    check({name, " drop_cnt"}, rx_drop_cnt, exp_drop);
    check({name, " stability"}, stab_err, 0);
    for (int i = 0; i < NIf; i++) begin
      check($sformatf("%s hs[%0d]", name, i), hs[i], exp_hs[i]);
      if (!(abort && i == 1))
        check($sformatf("%s vcyc[%0d]", name, i), vcyc[i], exp_hs[i] ? 1 + hold[i] : 0);
    end
  endtask

  task automatic set_timing(input int h, input int l);
    for (int i = 0; i < NIf; i++) begin
      hold[i]   = h;
      waited[i] = 0;
    end
    lat_cam = l;
    lat_rd  = l;
  endtask

  initial begin
    rst = 1'b1; rst_req = 1'b0; prev_rst = 1'b1;
    rx_hdr_val = 1'b0; rx_hdr_syn = 1'b0;
    read_flow_cam_rdy = 1'b0; read_flow_cam_resp_val = 1'b0; read_flow_cam_hit = 1'b0;
    flow_rd_req_rdy = 1'b0; flow_rd_resp_val = 1'b0; flow_wr_req_rdy = 1'b0;
    rx_sched_update_rdy = 1'b0; tcp_rx_dst_hdr_rdy = 1'b0; flowid_manager_req_rdy = 1'b0;
    new_flow_rdy = 1'b0; app_new_flow_notif_rdy = 1'b0; slow_path_send_pkt_enqueue_rdy = 1'b0;
    hdr_pending = 1'b0; cam_cd = 0; rd_cd = 0; exp_drop = 0;
    prev_v = '0; prev_r = '0;
    set_timing(0, 1);

    repeat (3) @(posedge clk);
    #2;
    check("reset rx_hdr_rdy", rx_hdr_rdy, 0);
    check("reset vals", get_val(), 0);
    check("reset drop_cnt", rx_drop_cnt, 0);
    check("reset save_input", ctrl_datap_save_input, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rdy after reset", rx_hdr_rdy, 1);

    set_timing(0, 1);
    run_segment("hit_fast", 1'b0, 1'b1, 1'b0);

    set_timing(0, 1);
    hold[4] = 5;
    run_segment("hit_dst_stall", 1'b0, 1'b1, 1'b0);

    set_timing(0, 1);
    for (int n = 0; n < 3; n++) run_segment($sformatf("drop%0d", n), 1'b0, 1'b0, 1'b0);
    check("drop total", rx_drop_cnt, 3);

    set_timing(0, 1);
    hold[5] = 10;
    run_segment("new_mgr_stall", 1'b1, 1'b0, 1'b0);

    set_timing(0, 1);
    lat_rd = 4;
    run_segment("abort_rdwait", 1'b0, 1'b1, 1'b1);
    lat_rd = 1;
    clear_counts();
    repeat (6) tick();
    check("no wr after abort", vcyc[2], 0);
    check("no drop after abort", rx_drop_cnt, 0);

    set_timing(0, 1);
    run_segment("hit_after_abort", 1'b0, 1'b1, 1'b0);

    set_timing(0, 1);
    run_segment("new_fast", 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      bit s, h;
      s = 1'($urandom);
      h = 1'($urandom);
      for (int i = 0; i < NIf; i++) begin
        hold[i]   = int'($urandom_range(0, 3));
        waited[i] = 0;
      end
      lat_cam = int'($urandom_range(1, 3));
      lat_rd  = int'($urandom_range(1, 3));
      run_segment($sformatf("rand%0d", n), s, h, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
